// File: rtl/debug_pkg.sv
// Shared debug-path types and widths for the latch dump sequencer,
// the UART and the debug unit.
package debug_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BIDX_W = 2;

  typedef enum logic [3:0] {
    IDLE,
    SELECT,
    WAIT_MUX,
    LOAD,
    SEND,
    WAIT_TX,
    NEXT,
    CSUM,
    FINISH
  } state_t;
endpackage

// File: rtl/word_byte_shifter.sv
// Holds one captured latch word and presents it MSB byte first.
module word_byte_shifter
  import debug_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  output logic [BYTE_W-1:0] top,
  output logic [BIDX_W-1:0] byte_idx,
  output logic              last
);
  logic [WORD_W-1:0] word;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word <= '0;
      byte_idx <= '0;
    end else if (load) begin
      word <= data;
      byte_idx <= '0;
    end else if (shift) begin
      word <= {word[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
      byte_idx <= byte_idx + 1'b1;
    end
  end

  assign top = word[WORD_W-1 -: BYTE_W];
  assign last = (byte_idx == BIDX_W'(BYTES_PER_WORD-1));
endmodule

// File: rtl/latch_dump_sequencer.sv
// Walks the latch mux and streams every word to the UART, MSB first.
// Optional trailing XOR checksum byte: define DUMP_CHECKSUM_EN.
module latch_dump_sequencer
  import debug_pkg::*;
#(
  parameter int NUM_WORDS = 28,
  parameter int SEL_W = 7,
  parameter int MUX_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic [SEL_W-1:0]  mux_sel,
  input  logic [WORD_W-1:0] mux_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_start,
  output logic              busy,
  output logic              done
);
  localparam int CNT_W = $clog2(MUX_LAT + 2);

  if (NUM_WORDS > (1 << SEL_W)) begin : g_width_chk
    $error("NUM_WORDS does not fit in SEL_W select bits");
  end

  state_t state, state_n;
  logic [SEL_W-1:0] word_idx;
  logic [CNT_W-1:0] cnt;
  logic [BYTE_W-1:0] top;
  logic [BIDX_W-1:0] byte_idx;
  logic last;

  logic clr, ld, sh, issue, sel_drive;
  logic cnt_load, cnt_dec, widx_inc, widx_clr;

`ifdef DUMP_CHECKSUM_EN
  logic [BYTE_W-1:0] csum;
  logic csum_phase;
  logic csum_issue;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end

  always_comb begin
    state_n = state;
    clr = 1'b0;
    ld = 1'b0;
    sh = 1'b0;
    issue = 1'b0;
    sel_drive = 1'b0;
    cnt_load = 1'b0;
    cnt_dec = 1'b0;
    widx_inc = 1'b0;
    widx_clr = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    csum_issue = 1'b0;
`endif
    if (abort && state != IDLE) begin
      state_n = IDLE;
      clr = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            state_n = SELECT;
            clr = 1'b1;
          end
        end
        SELECT: begin
          sel_drive = 1'b1;
          if (MUX_LAT == 0) begin
            state_n = LOAD;
          end else begin
            cnt_load = 1'b1;
            state_n = WAIT_MUX;
          end
        end
        WAIT_MUX: begin
          cnt_dec = 1'b1;
          if (cnt <= CNT_W'(1)) state_n = LOAD;
        end
        LOAD: begin
          ld = 1'b1;
          state_n = SEND;
        end
        SEND: begin
          if (!tx_busy) begin
            issue = 1'b1;
            state_n = WAIT_TX;
          end
        end
        WAIT_TX: begin
          if (tx_done) begin
`ifdef DUMP_CHECKSUM_EN
            if (csum_phase) begin
              state_n = FINISH;
            end else begin
              sh = 1'b1;
              state_n = last ? NEXT : SEND;
            end
`else
            sh = 1'b1;
            state_n = last ? NEXT : SEND;
`endif
          end
        end
        NEXT: begin
          if (word_idx == SEL_W'(NUM_WORDS-1)) begin
`ifdef DUMP_CHECKSUM_EN
            state_n = CSUM;
`else
            state_n = FINISH;
`endif
          end else begin
            widx_inc = 1'b1;
            state_n = SELECT;
          end
        end
`ifdef DUMP_CHECKSUM_EN
        CSUM: begin
          if (!tx_busy) begin
            csum_issue = 1'b1;
            state_n = WAIT_TX;
          end
        end
`endif
        FINISH: begin
          widx_clr = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mux_sel <= '0;
      tx_data <= '0;
      tx_start <= 1'b0;
      word_idx <= '0;
      cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      if (clr || widx_clr) begin
        word_idx <= '0;
        mux_sel <= '0;
        cnt <= '0;
      end
      if (sel_drive) mux_sel <= word_idx;
      if (cnt_load) cnt <= CNT_W'(MUX_LAT);
      else if (cnt_dec) cnt <= cnt - 1'b1;
      if (widx_inc) word_idx <= word_idx + 1'b1;
      if (issue) begin
        tx_data <= top;
        tx_start <= 1'b1;
      end
`ifdef DUMP_CHECKSUM_EN
      if (csum_issue) begin
        tx_data <= csum;
        tx_start <= 1'b1;
      end
`endif
    end
  end

`ifdef DUMP_CHECKSUM_EN
  // The checksum byte itself is not folded into the running XOR.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      csum <= '0;
      csum_phase <= 1'b0;
    end else begin
      if (issue) csum <= csum ^ top;
      if (csum_issue) csum_phase <= 1'b1;
    end
  end
`endif

  word_byte_shifter u_shift (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .load    (ld),
    .shift   (sh),
    .data    (mux_data),
    .top     (top),
    .byte_idx(byte_idx),
    .last    (last)
  );

  assign busy = (state != IDLE) && (state != FINISH);
  assign done = (state == FINISH);
endmodule

// File: tb/tb_latch_dump_sequencer.sv
// Scoreboard bench for latch_dump_sequencer with a registered mux and UART model.
module tb_latch_dump_sequencer;
  localparam int NW = 3;
`ifdef DUMP_CHECKSUM_EN
  localparam int NB = 4 * NW + 1;
`else
  localparam int NB = 4 * NW;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic [6:0] mux_sel;
  logic [31:0] mux_data = '0;
  logic tx_busy, tx_done;
  logic [7:0] tx_data;
  logic tx_start, busy, done;

  logic ubusy = 1'b0;
  logic udone = 1'b0;
  int ucnt = 0;
  logic hold_busy = 1'b0;
  logic inj_done = 1'b0;

  int total = 0;
  int bad = 0;
  int nbytes = 0;
  int ndone = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [6:0] word;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[NB];

  always #5 clk = ~clk;

  always_ff @(posedge clk) mux_data <= 32'hA0B0C0D0 + {25'd0, mux_sel};

  always @(posedge clk) begin
    udone <= 1'b0;
    if (tx_start && !ubusy) begin
      ubusy <= 1'b1;
      ucnt <= 10;
    end else if (ubusy) begin
      ucnt <= ucnt - 1;
      if (ucnt == 1) begin
        ubusy <= 1'b0;
        udone <= 1'b1;
      end
    end
  end
  assign tx_busy = ubusy | hold_busy;
  assign tx_done = udone | inj_done;

  latch_dump_sequencer #(.NUM_WORDS(NW), .SEL_W(7), .MUX_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mux_sel(mux_sel), .mux_data(mux_data),
    .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_data(tx_data), .tx_start(tx_start),
    .busy(busy), .done(done)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (tx_start) begin
      nbytes++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_byte: got %h want none at %0t", tx_data, $time);
      end else begin
        chk("byte", {24'd0, tx_data}, {24'd0, sb.pop_front()});
      end
    end
    if (done) begin
      ndone++;
      chk("busy_at_done", {31'd0, busy}, 32'd0);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(int n);
    for (int i = 0; i < n; i++) sb.push_back(tbl[i].exp);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clr_cnt();
    nbytes = 0;
    ndone = 0;
    sb.delete();
  endtask

  task automatic wait_done(int budget);
    int d0 = ndone;
    int i = 0;
    while (ndone == d0 && i < budget) begin
      tick();
      i++;
    end
    chk("done_timeout", {31'd0, ndone != d0}, 32'd1);
  endtask

  task automatic wait_bytes(int n, int budget);
    int i = 0;
    while (nbytes < n && i < budget) begin
      tick();
      i++;
    end
    chk("bytes_timeout", {31'd0, nbytes >= n}, 32'd1);
  endtask

  task automatic full_run(string tag);
    wait_done(3000);
    tick(3);
    chk({tag, "_nbytes"}, nbytes, NB);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_sb_empty"}, sb.size(), 0);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int i;
    tbl[0] = '{7'd0, 8'hA0}; tbl[1] = '{7'd0, 8'hB0};
    tbl[2] = '{7'd0, 8'hC0}; tbl[3] = '{7'd0, 8'hD0};
    tbl[4] = '{7'd1, 8'hA0}; tbl[5] = '{7'd1, 8'hB0};
    tbl[6] = '{7'd1, 8'hC0}; tbl[7] = '{7'd1, 8'hD1};
    tbl[8] = '{7'd2, 8'hA0}; tbl[9] = '{7'd2, 8'hB0};
    tbl[10] = '{7'd2, 8'hC0}; tbl[11] = '{7'd2, 8'hD2};
`ifdef DUMP_CHECKSUM_EN
    tbl[12] = '{7'd0, 8'h03};
`endif

    tick(3);
    chk("rst_mux_sel", {25'd0, mux_sel}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick(2);

    clr_cnt();
    push(NB);
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    full_run("basic");

    clr_cnt();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_wins_busy", {31'd0, busy}, 32'd0);
    tick(5);
    chk("abort_wins_nbytes", nbytes, 0);

    clr_cnt();
    push(NB);
    hold_busy = 1'b1;
    pulse_start();
    tick(50);
    chk("hold_no_start", nbytes, 0);
    hold_busy = 1'b0;
    full_run("hold");

    clr_cnt();
    push(NB);
    pulse_start();
    wait_bytes(5, 500);
    pulse_start();
    full_run("restart_ignored");

    clr_cnt();
    push(6);
    pulse_start();
    wait_bytes(6, 500);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_mux_sel", {25'd0, mux_sel}, 32'd0);
    chk("abort_tx_start", {31'd0, tx_start}, 32'd0);
    tick(40);
    chk("abort_nbytes", nbytes, 6);
    chk("abort_ndone", ndone, 0);
    clr_cnt();
    push(NB);
    pulse_start();
    full_run("after_abort");

    clr_cnt();
    push(4);
    pulse_start();
    wait_bytes(4, 500);
    i = 0;
    while (mux_sel != 7'd1 && i < 200) begin
      tick();
      i++;
    end
    chk("reach_word1", {25'd0, mux_sel}, 32'd1);
    rst = 1'b1;
    tick();
    chk("mrst_mux_sel", {25'd0, mux_sel}, 32'd0);
    chk("mrst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("mrst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    tick(2);
    for (int k = 0; k < 3; k++) begin
      inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
      tick(3);
    end
    tick(10);
    chk("mrst_nbytes", nbytes, 4);
    chk("mrst_ndone", ndone, 0);
    chk("mrst_busy_idle", {31'd0, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
